// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one word request at a time, LATENCY wait cycles, one-cycle ack.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned requests via err_o and suppress their effect.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_mis;
  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     r_rdata;
  logic            r_err;

  logic            w_accept;
  logic            w_exec;
  logic            w_in_mis;
  logic            w_ex_we;
  logic [AW-1:0]   w_ex_idx;
  logic [31:0]     w_ex_wdata;
  logic            w_ex_mis;
  logic            w_unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_in_mis = (addr_i[1:0] != 2'b00);
`else
  assign w_in_mis = 1'b0;
`endif

  assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
  assign w_accept      = (r_state == S_IDLE) && req_i;
  assign w_exec        = (w_next == S_RESP) && (r_state != S_RESP);

  // With LATENCY = 0 the request executes on its own acceptance edge, so take it straight from the inputs.
  assign w_ex_we    = (r_state == S_IDLE) ? we_i           : r_we;
  assign w_ex_idx   = (r_state == S_IDLE) ? addr_i[AW+1:2] : r_idx;
  assign w_ex_wdata = (r_state == S_IDLE) ? wdata_i        : r_wdata;
  assign w_ex_mis   = (r_state == S_IDLE) ? w_in_mis       : r_mis;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= LAT4;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_i) w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt <= 4'd1) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (r_state == S_IDLE);
    ack_o   = (r_state == S_RESP);
    err_o   = (r_state == S_RESP) && r_err;
    rdata_o = r_rdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_mis   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= we_i;
      r_idx   <= addr_i[AW+1:2];
      r_wdata <= wdata_i;
      r_mis   <= w_in_mis;
    end
  end

  // Reset clears the array, which also discards any store that has not yet executed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_exec) begin
      r_err <= w_ex_mis;
      if (w_ex_we) begin
        if (!w_ex_mis) r_mem[w_ex_idx] <= w_ex_wdata;
        r_rdata <= 32'd0;
      end else begin
        r_rdata <= w_ex_mis ? 32'd0 : r_mem[w_ex_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses LATENCY=2, instance 1 uses LATENCY=0; both DEPTH=128.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(128), .LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .ready_o(ready[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0])
  );

  dmem_responder #(.DEPTH(128), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .ready_o(ready[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1])
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: called at posedge+1 with the DUT idle; returns ack latency (cycles after the request cycle, -1 on timeout).
  task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er,
                       output int rlow, output logic rdy_after, output int stray);
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
    @(posedge clk); #1;
    req[s] = 1'b0;
    lat = -1; rd = 32'd0; er = 1'b0; rlow = 0; stray = 0; rdy_after = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (!ready[s]) rlow++;
      if (err[s] && !ack[s]) stray++;
      if (ack[s]) begin
        lat = k; rd = rdata[s]; er = err[s];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rdy_after = ready[s];
    if (err[s]) stray++;
  endtask

  task automatic test_reset();
    int lat, rlow, stray; logic [31:0] rd; logic er, ra;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; we[s] = 1'b0; addr[s] = 32'd0; wdata[s] = 32'd0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready[0]); end
    checks++; if (ack[0] !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack[0]); end
    checks++; if (rdata[0] !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata[0]); end
    checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err[0]); end
    checks++; if (ready[1] !== 1'b1) begin failures++; $display("FAIL reset_ready0 got=%b exp=1", ready[1]); end
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h14;
    @(posedge clk); #1;
    req[0] = 1'b0;
    checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL wait_ready got=%b exp=0", ready[0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL async_rst_ready got=%b exp=1", ready[0]); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack[0] !== 1'b0) begin failures++; $display("FAIL aborted_load_ack got=%b exp=0", ack[0]); end
    issue(0, 1'b0, 32'h14, 32'd0, lat, rd, er, rlow, ra, stray);
    checks++; if (lat !== 3) begin failures++; $display("FAIL reset_load_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_load_data got=%h exp=0", rd); end
  endtask

  task automatic test_store_load();
    int lat, rlow, stray; logic [31:0] rd; logic er, ra;
    issue(0, 1'b1, 32'h14, 32'hDEADBEEF, lat, rd, er, rlow, ra, stray);
    checks++; if (lat !== 3) begin failures++; $display("FAIL store_latency got=%0d exp=3", lat); end
    checks++; if (rlow !== 3) begin failures++; $display("FAIL store_ready_low got=%0d exp=3", rlow); end
    checks++; if (ra !== 1'b1) begin failures++; $display("FAIL store_ready_return got=%b exp=1", ra); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL store_rdata got=%h exp=0", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL store_err got=%b exp=0", er); end
    issue(0, 1'b0, 32'h14, 32'd0, lat, rd, er, rlow, ra, stray);
    checks++; if (lat !== 3) begin failures++; $display("FAIL load_latency got=%0d exp=3", lat); end
    checks++; if (rlow !== 3) begin failures++; $display("FAIL load_ready_low got=%0d exp=3", rlow); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data got=%h exp=deadbeef", rd); end
    checks++; if (rdata[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data_held got=%h exp=deadbeef", rdata[0]); end
  endtask

  task automatic test_back_to_back();
    int lat, rlow, stray; logic [31:0] rd; logic er, ra;
    issue(1, 1'b1, 32'h0, 32'hAAAA0000, lat, rd, er, rlow, ra, stray);
    checks++; if (lat !== 1) begin failures++; $display("FAIL l0_store_latency got=%0d exp=1", lat); end
    checks++; if (rlow !== 1) begin failures++; $display("FAIL l0_ready_low got=%0d exp=1", rlow); end
    issue(1, 1'b1, 32'h4, 32'h55550000, lat, rd, er, rlow, ra, stray);
    checks++; if (ra !== 1'b1) begin failures++; $display("FAIL l0_ready_return got=%b exp=1", ra); end
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    @(posedge clk); #1;
    checks++; if (ack[1] !== 1'b1) begin failures++; $display("FAIL b2b_ack1 got=%b exp=1", ack[1]); end
    checks++; if (rdata[1] !== 32'hAAAA0000) begin failures++; $display("FAIL b2b_data1 got=%h exp=aaaa0000", rdata[1]); end
    addr[1] = 32'h4;
    @(posedge clk); #1;
    checks++; if (ack[1] !== 1'b0) begin failures++; $display("FAIL b2b_gap_ack got=%b exp=0", ack[1]); end
    checks++; if (ready[1] !== 1'b1) begin failures++; $display("FAIL b2b_gap_ready got=%b exp=1", ready[1]); end
    checks++; if (rdata[1] !== 32'hAAAA0000) begin failures++; $display("FAIL b2b_data_hold got=%h exp=aaaa0000", rdata[1]); end
    @(posedge clk); #1;
    checks++; if (ack[1] !== 1'b1) begin failures++; $display("FAIL b2b_ack2 got=%b exp=1", ack[1]); end
    checks++; if (rdata[1] !== 32'h55550000) begin failures++; $display("FAIL b2b_data2 got=%h exp=55550000", rdata[1]); end
    req[1] = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack[1] !== 1'b0) begin failures++; $display("FAIL b2b_end_ack got=%b exp=0", ack[1]); end
    @(posedge clk); #1;
    checks++; if (ack[1] !== 1'b0) begin failures++; $display("FAIL b2b_idle_ack got=%b exp=0", ack[1]); end
  endtask

  task automatic test_wrap();
    int lat, rlow, stray; logic [31:0] rd; logic er, ra;
    issue(0, 1'b1, 32'h200, 32'h11, lat, rd, er, rlow, ra, stray);
    issue(0, 1'b0, 32'h0, 32'd0, lat, rd, er, rlow, ra, stray);
    checks++; if (rd !== 32'h11) begin failures++; $display("FAIL wrap_data got=%h exp=11", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL wrap_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_reset_mid_store();
    int lat, rlow, stray, acks; logic [31:0] rd; logic er, ra;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (rdata[0] !== 32'd0) begin failures++; $display("FAIL midrst_rdata got=%h exp=0", rdata[0]); end
    checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready[0]); end
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      if (ack[0]) acks++;
      @(posedge clk); #1;
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL midrst_no_ack got=%0d exp=0", acks); end
    issue(0, 1'b0, 32'h8, 32'd0, lat, rd, er, rlow, ra, stray);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL midrst_load got=%h exp=0", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL midrst_latency got=%0d exp=3", lat); end
    issue(0, 1'b0, 32'h14, 32'd0, lat, rd, er, rlow, ra, stray);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL midrst_cleared got=%h exp=0", rd); end
  endtask

  task automatic test_align();
    int lat, rlow, stray; logic [31:0] rd; logic er, ra;
    logic        exp_err_mis;
    logic [31:0] exp_w1, exp_mis_load;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_err_mis = 1'b1; exp_w1 = 32'd0;         exp_mis_load = 32'd0;
`else
    exp_err_mis = 1'b0; exp_w1 = 32'h12345678;  exp_mis_load = 32'h9;
`endif
    issue(0, 1'b1, 32'h6, 32'h12345678, lat, rd, er, rlow, ra, stray);
    checks++; if (er !== exp_err_mis) begin failures++; $display("FAIL mis_store_err got=%b exp=%b", er, exp_err_mis); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL mis_store_latency got=%0d exp=3", lat); end
    checks++; if (stray !== 0) begin failures++; $display("FAIL mis_store_err_outside_ack got=%0d exp=0", stray); end
    issue(0, 1'b0, 32'h4, 32'd0, lat, rd, er, rlow, ra, stray);
    checks++; if (rd !== exp_w1) begin failures++; $display("FAIL align_load_word1 got=%h exp=%h", rd, exp_w1); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL align_load_err got=%b exp=0", er); end
    issue(0, 1'b1, 32'h4, 32'h9, lat, rd, er, rlow, ra, stray);
    issue(0, 1'b0, 32'h5, 32'd0, lat, rd, er, rlow, ra, stray);
    checks++; if (rd !== exp_mis_load) begin failures++; $display("FAIL mis_load_data got=%h exp=%h", rd, exp_mis_load); end
    checks++; if (er !== exp_err_mis) begin failures++; $display("FAIL mis_load_err got=%b exp=%b", er, exp_err_mis); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_wrap();
    test_reset_mid_store();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
